// File: rtl/fire_button_ctrl_if.sv
// Signal bundle between the button debouncer/game logic and fire_button_ctrl.
// master drives the button level and fire enable; slave produces the game events.
interface fire_button_ctrl_if;
    logic       btn_in;
    logic       fire_en;
    logic       press_pulse;
    logic       release_pulse;
    logic       fire_pulse;
    logic       held;
    logic [7:0] shot_count;

    modport master (
        output btn_in,
        output fire_en,
        input  press_pulse,
        input  release_pulse,
        input  fire_pulse,
        input  held,
        input  shot_count
    );

    modport slave (
        input  btn_in,
        input  fire_en,
        output press_pulse,
        output release_pulse,
        output fire_pulse,
        output held,
        output shot_count
    );
endinterface

// File: rtl/fire_button_ctrl.sv
// Turns a debounced button level into press/release pulses, a long-press level and
// rate-limited fire pulses. Define FIRE_AUTOREPEAT_EN to enable auto-repeat fire.
module fire_button_ctrl #(
    parameter int unsigned HOLD_CYCLES     = 5_000_000,
    parameter int unsigned REPEAT_CYCLES   = 1_000_000,
    parameter int unsigned COOLDOWN_CYCLES = 500_000,
    parameter int unsigned CNT_W           = 24
) (
    input logic               clk,
    input logic               rst,
    fire_button_ctrl_if.slave btn_if
);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
    // A cooldown of 0 or 1 cycles never blocks the next attempt.
    localparam logic [CNT_W-1:0] CdLoad   =
        (COOLDOWN_CYCLES <= 1) ? '0 : CNT_W'(COOLDOWN_CYCLES - 1);

    state_e           state_q, state_d;
    logic             btn_q;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
    logic [7:0]       shot_q, shot_d;
    logic             press_q, release_q, fire_q, held_q;
    logic             held_d;
    logic             rise, fall;
    logic             fire_attempt, fire_emit;

`ifdef FIRE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    assign rise = btn_if.btn_in & ~btn_q;
    assign fall = ~btn_if.btn_in & btn_q;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        fire_attempt = 1'b0;
`ifdef FIRE_AUTOREPEAT_EN
        rep_cnt_d    = rep_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d      = StHold;
                    hold_cnt_d   = '0;
                    fire_attempt = 1'b1;
                end
            end
            StHold: begin
                // Release has priority over reaching the long-press threshold.
                if (fall) begin
                    state_d = StIdle;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d = StRepeat;
`ifdef FIRE_AUTOREPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
                    hold_cnt_d = hold_cnt_q + CntOne;
                end
            end
            StRepeat: begin
                if (fall) begin
                    state_d = StIdle;
`ifdef FIRE_AUTOREPEAT_EN
                end else if (rep_cnt_q == RepLast) begin
                    fire_attempt = 1'b1;
                    rep_cnt_d    = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + CntOne;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Attempts blocked by fire_en or cooldown are dropped, never queued.
    always_comb begin
        fire_emit = fire_attempt & btn_if.fire_en & (cd_cnt_q == '0);
        if (fire_emit) begin
            cd_cnt_d = CdLoad;
        end else if (cd_cnt_q != '0) begin
            cd_cnt_d = cd_cnt_q - CntOne;
        end else begin
            cd_cnt_d = cd_cnt_q;
        end
        shot_d = shot_q + {7'd0, fire_emit};
        held_d = (state_d == StRepeat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            btn_q      <= 1'b0;
            hold_cnt_q <= '0;
            cd_cnt_q   <= '0;
            shot_q     <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            fire_q     <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_if.btn_in;
            hold_cnt_q <= hold_cnt_d;
            cd_cnt_q   <= cd_cnt_d;
            shot_q     <= shot_d;
            press_q    <= rise;
            release_q  <= fall;
            fire_q     <= fire_emit;
            held_q     <= held_d;
        end
    end

`ifdef FIRE_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign btn_if.press_pulse   = press_q;
    assign btn_if.release_pulse = release_q;
    assign btn_if.fire_pulse    = fire_q;
    assign btn_if.held          = held_q;
    assign btn_if.shot_count    = shot_q;

endmodule
